// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit in front of the data RAM.
// One request at a time; sub-word stores are done as read-modify-write.
module lsu #(
  parameter int ADDR_W     = 12,
  parameter int WORD_BYTES = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              Wr,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Wdata,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [31:0]       Rdata,
  output logic [ADDR_W-1:0] Ram_addr,
  output logic              Ram_cs,
  output logic              Ram_we,
  output logic [31:0]       Ram_wdata,
  input  logic [31:0]       Ram_rdata,
  input  logic              Ram_ack
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       wdata_lo_q, wdata_lo_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   end_addr;
  logic              req_bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign base     = {Addr[ADDR_W-1:2], 2'b00};
  assign end_addr = {1'b0, base} + (ADDR_W+1)'(WORD_BYTES);

  // The range term only matters for a partially populated address map.
  always_comb begin
    req_bad = 1'b0;
    case (Size)
      2'd0: req_bad = 1'b0;
      2'd1: req_bad = Addr[0];
      2'd2: req_bad = (Addr[1:0] != 2'd0);
      default: req_bad = 1'b1;
    endcase
    if (end_addr > ADDR_LIMIT) begin
      req_bad = 1'b1;
    end
  end

  always_comb begin
    byte_sel = Ram_rdata[7:0];
    case (lane_q)
      2'd0: byte_sel = Ram_rdata[7:0];
      2'd1: byte_sel = Ram_rdata[15:8];
      2'd2: byte_sel = Ram_rdata[23:16];
      default: byte_sel = Ram_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? Ram_rdata[31:16] : Ram_rdata[15:0];
    case (size_q)
      2'd0: load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1: load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = Ram_rdata;
    endcase
  end

  // Sub-word store: replace the addressed lane(s) of the word just read.
  always_comb begin
    merged = Ram_rdata;
    if (size_q == 2'd0) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_lo_q[7:0];
        2'd1: merged[15:8]  = wdata_lo_q[7:0];
        2'd2: merged[23:16] = wdata_lo_q[7:0];
        default: merged[31:24] = wdata_lo_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_lo_q;
    end else begin
      merged[15:0] = wdata_lo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_lo_d  = wdata_lo_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_cs_d    = ram_cs_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          wr_d       = Wr;
          size_d     = Size;
          uns_d      = Unsigned;
          lane_d     = Addr[1:0];
          wdata_lo_d = Wdata[15:0];
          ram_addr_d = base;
          if (req_bad) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (Wr && (Size == 2'd2)) begin
            state_d     = ST_WR;
            ram_cs_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_wdata_d = Wdata;
          end else begin
            state_d  = ST_RD;
            ram_cs_d = 1'b1;
            ram_we_d = 1'b0;
          end
        end
      end
      ST_RD: begin
        if (Ram_ack) begin
          ram_cs_d = 1'b0;
          if (wr_q) begin
            ram_wdata_d = merged;
            state_d     = ST_MERGE;
          end else begin
            rdata_d = load_val;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_MERGE: begin
        ram_cs_d = 1'b1;
        ram_we_d = 1'b1;
        state_d  = ST_WR;
      end
      ST_WR: begin
        if (Ram_ack) begin
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      lane_q      <= 2'd0;
      wdata_lo_q  <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      ram_addr_q  <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_lo_q  <= wdata_lo_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign Err       = err_q;
  assign Rdata     = rdata_q;
  assign Ram_addr  = ram_addr_q;
  assign Ram_cs    = ram_cs_q;
  assign Ram_we    = ram_we_q;
  assign Ram_wdata = ram_wdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data RAM. It accepts one load or store request at a time from the core's memory stage and turns it into the RAM's Cs/We/Ack single-access handshake. Sub-word stores are done as read-modify-write. Load data is lane-selected and sign- or zero-extended. Misaligned and out-of-range requests are rejected without touching the RAM.

## Interface
- ADDR_W, default 12: byte-address width; equals $clog2 of the RAM capacity in bytes.
- WORD_BYTES, default 4: word size in bytes. Fixed at 4 for this revision; the RAM capacity is a multiple of 4.
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req  in  1  request strobe; sampled only when Busy=0.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises Err.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Addr  in  ADDR_W  byte address.
- Wdata  in  32  store data; the low byte or half is used for sub-word stores.
- Busy  out  1  a request is in flight.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  valid with Done; the request was rejected.
- Rdata  out  32  extended load result.
- Ram_addr  out  ADDR_W  word-aligned byte address to the RAM.
- Ram_cs  out  1  RAM chip select.
- Ram_we  out  1  RAM write enable.
- Ram_wdata  out  32  RAM write word.
- Ram_rdata  in  32  RAM read word; valid while Ram_ack=1.
- Ram_ack  in  1  RAM acknowledge pulse.

## Operation
- States: IDLE, RD, MERGE, WR, ERR.
- Ram_cs, Ram_we, Ram_addr and Ram_wdata are all registered.

**Request acceptance (IDLE)**
- A request is accepted when Req=1 and the state is IDLE.
- At acceptance, Addr, Wr, Size, Unsigned and Wdata are latched. Nothing is sampled in any other state.
- Lane = Addr[1:0]. Base = Addr with bits [1:0] cleared; Ram_addr is always Base.

**Error check at acceptance**
- Err cases:
  - Size=3;
  - Size=1 with Addr[0]=1;
  - Size=2 with Addr[1:0]≠0;
  - Base + 4 > 2^ADDR_W (cannot occur when ADDR_W covers the full RAM; the check is kept for a partially populated map).
- On error: go to ERR. Ram_cs stays 0.

**Next state after a legal request**
- Load, or any sub-word store: go to RD, with Ram_cs=1 and Ram_we=0.
- Word store: go to WR, with Ram_cs=1, Ram_we=1 and Ram_wdata=Wdata.

**RD**
- Hold Ram_cs until Ram_ack=1 is sampled.
- On that edge: Ram_cs←0 and the read word is captured.
- Load: produce the result (below); Done←1; go to IDLE.
- Sub-word store: build the merged word by replacing byte lane Lane (Size=0) or bytes Lane..Lane+1 (Size=1) of the read word with the low byte/half of Wdata. Go to MERGE.

**Load result**
- Byte lane k occupies bits 8k+7:8k (little-endian).
- Select byte Lane or half Lane/2, then sign- or zero-extend to 32 bits.

**MERGE**
- Exactly one cycle with Ram_cs=0.
- Then go to WR with Ram_cs=1, Ram_we=1 and Ram_wdata=merged word.

**WR**
- Hold until Ram_ack=1 is sampled.
- On that edge: Ram_cs←0, Ram_we←0, Done←1, go to IDLE.

**ERR**
- Done=1 and Err=1 for one cycle, then return to IDLE.

**Outputs and status**
- Busy = (state ≠ IDLE).
- Rdata is updated only on successful load completion and holds otherwise.
- Ram_ack is ignored in IDLE, MERGE and ERR.
- Ram_cs is never high on the cycle after Ram_ack was sampled. The RAM re-triggers if Cs is held, so this rule is mandatory.

## Timing
- Reset values: state=IDLE; Busy=0, Done=0, Err=0, Rdata=0, Ram_cs=0, Ram_we=0, Ram_addr=0, Ram_wdata=0.
- Reset mid-operation: everything returns immediately to the reset values. The RAM is reset by the same system reset, so a pending RAM Ack is not tracked.
- Latencies are counted from the accepting edge E0; "Done after Ek" means Done is high in the cycle following edge Ek.
- Load or word store: Ram_cs high after E0; RAM Ack high after E1; Done after E2.
- Sub-word store:
  - read phase: Ram_cs high E0–E2;
  - MERGE: Ram_cs low E2–E3;
  - write phase: Ram_cs high E3–E5;
  - Done after E5.
- Error: Done=1 and Err=1 after E0.
- Back-to-back: the state is IDLE during the Done cycle, so a new Req is accepted on the edge ending that cycle.
- Done and Err are single-cycle pulses.

## Test plan
- Word store at 0x010 with Wdata=0xDEADBEEF, then word load at 0x010 → Done after E2 for each; Rdata=0xDEADBEEF; Err=0.
- Byte store 0x5A at 0x012 over a word at 0x010 holding 0x11223344 → one read, one MERGE cycle with Ram_cs=0, write of 0x115A3344; Done after E5.
- Byte load at 0x013 of word 0x80FF7F01: Unsigned=0 → Rdata=0xFFFFFF80; Unsigned=1 → Rdata=0x00000080.
- Half load at 0x012 of word 0x8001ABCD with Unsigned=0 → Rdata=0xFFFF8001.
- Misaligned half at 0x011, word at 0x012, and Size=3 → Done=1 and Err=1 one cycle after acceptance; Ram_cs never asserted; Rdata unchanged.
- Assert Rst_n=0 while in WR with Ram_cs=1 → all outputs go to 0 immediately; after release, a word load at 0x000 completes normally. Also check Req issued during the Done cycle is accepted and Ram_cs never stays high on the cycle after an Ack.
